// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud constants
// Contents:
//   CLKS_PER_BIT_9600  default clocks per bit (100 MHz / 9600 baud)
//   uart_state_e       transmit FSM state encoding
package uart_pkg;
    localparam int CLKS_PER_BIT_9600 = 10417;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: divides clk into bit periods of CLKS_PER_BIT cycles
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active high
//   clear     in   hold the counter at zero
//   bit_tick  out  high on the last cycle of each bit period
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_tick = cnt_q == LAST;
        cnt_d    = (clear || bit_tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: sends a parallel word as start, data LSB first, optional parity, stop
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active high
//   tx_start  in   send request, sampled only while idle
//   tx_data   in   word to send, captured on the accepting edge
//   tx        out  registered serial line, idles high
//   tx_busy   out  high from accept to end of the last stop bit
//   tx_done   out  one-cycle pulse when the frame completes
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_tick;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == IDLE),
        .bit_tick (bit_tick)
    );

    // tx_d is the value the line takes for the next bit, so tx stays a pure flop output
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tx_start) begin
                shift_d = tx_data;
                par_d   = ^tx_data ^ PARITY_ODD;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                state_d = START;
            end
            START: if (bit_tick) begin
                bit_d   = '0;
                tx_d    = shift_q[0];
                state_d = DATA;
            end
            DATA: if (bit_tick) begin
                shift_d = shift_q >> 1;
                bit_d   = (bit_q == LAST_DATA) ? '0 : bit_q + BW'(1);
                tx_d    = (bit_q != LAST_DATA) ? shift_q[1] : (PARITY_EN ? par_q : 1'b1);
                state_d = (bit_q != LAST_DATA) ? DATA : (PARITY_EN ? PARITY : STOP);
            end
            PARITY: if (bit_tick) begin
                tx_d    = 1'b1;
                state_d = STOP;
            end
            STOP: if (bit_tick) begin
                if (bit_q == LAST_STOP) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
endmodule
